// File: rtl/apb_rr_xbar.sv
// N-master to M-slave APB3 interconnect with round-robin arbitration, address decode,
// registered downstream bus and PSLVERR on unmapped addresses or slave timeouts.
module apb_rr_xbar #(
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter logic [SLAVE_PORTS*ADDR_WIDTH-1:0] SLAVE_BASE = {
    16'h0700, 16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000},
  parameter logic [SLAVE_PORTS*ADDR_WIDTH-1:0] SLAVE_MASK = {8{16'hFF00}},
  parameter int TIMEOUT      = 255,
  localparam int MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1,
  localparam int SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MASTER_PORTS*ADDR_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSEL,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  output logic [ADDR_WIDTH-1:0]              M_PADDR,
  output logic                               M_PWRITE,
  output logic [SLAVE_PORTS-1:0]             M_PSEL,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]             M_PREADY,
  input  logic [SLAVE_PORTS-1:0]             M_PSLVERR,
  output logic                               busy,
  output logic [MW-1:0]                      gnt_idx
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                           state;
  logic [MW-1:0]                    last;
  logic [MW-1:0]                    arb_gnt;
  logic [MW-1:0]                    arb_cand;
  logic                             arb_found;
  logic [ADDR_WIDTH-1:0]            arb_addr;
  logic [SW-1:0]                    slv;
  logic [SW-1:0]                    dec_slv;
  logic                             dec_hit;
  logic [31:0]                      tcnt;
  logic                             slv_ready;
  logic                             slv_err;
  logic                             timed_out;
  logic [MASTER_PORTS-1:0]          arb_onehot;
  logic [MASTER_PORTS-1:0]          cur_onehot;
  logic [SLAVE_PORTS-1:0]           dec_onehot;
  logic [MASTER_PORTS*DATA_WIDTH-1:0] rdata_slot;

  // Round-robin search starting just after the last granted master.
  always_comb begin
    arb_gnt   = last;
    arb_cand  = last;
    arb_found = 1'b0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      arb_cand = MW'((int'(last) + k) % MASTER_PORTS);
      if (!arb_found && S_PSEL[arb_cand]) begin
        arb_found = 1'b1;
        arb_gnt   = arb_cand;
      end
    end
  end

  assign arb_addr = S_PADDR[arb_gnt*ADDR_WIDTH +: ADDR_WIDTH];

  // Descending scan so the lowest matching slave index wins on overlapping windows.
  always_comb begin
    dec_hit = 1'b0;
    dec_slv = '0;
    for (int s = SLAVE_PORTS - 1; s >= 0; s--) begin
      if ((arb_addr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec_hit = 1'b1;
        dec_slv = SW'(s);
      end
    end
  end

  always_comb begin
    arb_onehot          = '0;
    arb_onehot[arb_gnt] = 1'b1;
    cur_onehot          = '0;
    cur_onehot[gnt_idx] = 1'b1;
    dec_onehot          = '0;
    dec_onehot[dec_slv] = 1'b1;
  end

  assign slv_ready = M_PREADY[slv];
  assign slv_err   = M_PSLVERR[slv];
  assign timed_out = (TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1));

  always_comb begin
    rdata_slot = '0;
    rdata_slot[gnt_idx*DATA_WIDTH +: DATA_WIDTH] =
      slv_ready ? M_PRDATA[slv*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Ready has priority over timeout when both land in the same ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= MW'(MASTER_PORTS - 1);
      gnt_idx   <= '0;
      slv       <= '0;
      tcnt      <= '0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PWDATA  <= '0;
      M_PSEL    <= '0;
      M_PENABLE <= 1'b0;
      S_PREADY  <= '0;
      S_PSLVERR <= '0;
      S_PRDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            last     <= arb_gnt;
            gnt_idx  <= arb_gnt;
            slv      <= dec_slv;
            M_PADDR  <= arb_addr;
            M_PWRITE <= S_PWRITE[arb_gnt];
            M_PWDATA <= S_PWDATA[arb_gnt*DATA_WIDTH +: DATA_WIDTH];
            if (dec_hit) begin
              M_PSEL <= dec_onehot;
              state  <= SETUP;
            end else begin
              S_PREADY  <= arb_onehot;
              S_PSLVERR <= arb_onehot;
              S_PRDATA  <= '0;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          M_PENABLE <= 1'b1;
          tcnt      <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (slv_ready || timed_out) begin
            M_PSEL    <= '0;
            M_PENABLE <= 1'b0;
            S_PREADY  <= cur_onehot;
            S_PSLVERR <= (slv_ready ? slv_err : 1'b1) ? cur_onehot : '0;
            S_PRDATA  <= rdata_slot;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        RESP: begin
          S_PREADY  <= '0;
          S_PSLVERR <= '0;
          S_PRDATA  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
